// File: rtl/ppu_spr_eval.sv
// ppu_spr_eval -- per-scanline sprite evaluation engine (i_ppu_clk domain).
//
// Scans all OAM entries through a RAM read port with a registered address, and
// keeps up to P_MAX_SPR in-range sprites, in OAM order, in a secondary buffer.
// It reports the hit count, an exact overflow flag and sprite-0 presence.
//
// Ports:
//   i_ppu_clk, i_ppu_rstn   clock, asynchronous active-low reset
//   i_start                 one-cycle start pulse (ignored while not idle)
//   i_line, i_spr_16        target scanline / 8x16 mode, sampled with i_start
//   o_oam_addr              OAM word address (to RAM address_b)
//   i_oam_rdata             OAM word {X, attr, tile, Y}, one cycle after address
//   o_busy, o_done          scan in progress / one-cycle results-valid pulse
//   o_spr_cnt, o_ovfl       sprites stored / more than P_MAX_SPR in range
//   o_spr0_in               OAM entry 0 was in range
//   i_rd_idx                secondary buffer read slot
//   o_rd_spr, o_rd_row      stored word and sprite row (line - Y)
//   o_rd_is0                slot holds OAM entry 0
module ppu_spr_eval #(
  parameter int unsigned P_MAX_SPR = 8,
  parameter int unsigned P_OAM_AW  = 6,
  localparam int unsigned L_IW = (P_MAX_SPR > 1) ? $clog2(P_MAX_SPR) : 1,
  localparam int unsigned L_CW = $clog2(P_MAX_SPR + 1)
) (
  input  logic                i_ppu_clk,
  input  logic                i_ppu_rstn,
  input  logic                i_start,
  input  logic [7:0]          i_line,
  input  logic                i_spr_16,
  output logic [P_OAM_AW-1:0] o_oam_addr,
  input  logic [31:0]         i_oam_rdata,
  output logic                o_busy,
  output logic                o_done,
  output logic [L_CW-1:0]     o_spr_cnt,
  output logic                o_ovfl,
  output logic                o_spr0_in,
  input  logic [L_IW-1:0]     i_rd_idx,
  output logic [31:0]         o_rd_spr,
  output logic [3:0]          o_rd_row,
  output logic                o_rd_is0
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t              state_q;
  logic [7:0]          line_q;
  logic                s16_q;
  logic [P_OAM_AW-1:0] addr_q;
  logic                iss_done_q;   // last address has been issued
  logic                p_v_q;        // i_oam_rdata carries entry p_idx_q
  logic [P_OAM_AW-1:0] p_idx_q;
  logic                busy_q;
  logic                done_q;
  logic [L_CW-1:0]     cnt_q;
  logic                ovfl_q;
  logic                spr0_q;

  logic [31:0] spr_q [P_MAX_SPR];
  logic [3:0]  row_q [P_MAX_SPR];
  logic        is0_q [P_MAX_SPR];

  logic [8:0] diff;
  logic       in_rng;
  logic       hit;
  logic       room;
  logic       last;

  // No wrap-around: a borrow out of line - Y (Y > line) is a miss.
  always_comb begin
    diff   = {1'b0, line_q} - {1'b0, i_oam_rdata[7:0]};
    in_rng = !diff[8] && (s16_q ? (diff[7:4] == 4'd0) : (diff[7:3] == 5'd0));
    hit    = p_v_q && in_rng;
    room   = (cnt_q < L_CW'(P_MAX_SPR));
    last   = p_v_q && (p_idx_q == '1);
  end

  always_ff @(posedge i_ppu_clk or negedge i_ppu_rstn) begin
    if (!i_ppu_rstn) begin
      state_q    <= S_IDLE;
      line_q     <= '0;
      s16_q      <= 1'b0;
      addr_q     <= '0;
      iss_done_q <= 1'b0;
      p_v_q      <= 1'b0;
      p_idx_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      ovfl_q     <= 1'b0;
      spr0_q     <= 1'b0;
      for (int unsigned i = 0; i < P_MAX_SPR; i++) begin
        spr_q[i] <= '1;
        row_q[i] <= '0;
        is0_q[i] <= 1'b0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            line_q     <= i_line;
            s16_q      <= i_spr_16;
            cnt_q      <= '0;
            ovfl_q     <= 1'b0;
            spr0_q     <= 1'b0;
            addr_q     <= '0;
            iss_done_q <= 1'b0;
            p_v_q      <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_SCAN;
            for (int unsigned i = 0; i < P_MAX_SPR; i++) begin
              spr_q[i] <= '1;
              row_q[i] <= '0;
              is0_q[i] <= 1'b0;
            end
          end
        end
        S_SCAN: begin
          // Address issued this cycle is registered by the RAM at this edge;
          // its data is evaluated at the following edge.
          p_v_q   <= !iss_done_q;
          p_idx_q <= addr_q;
          if (addr_q == '1) begin
            iss_done_q <= 1'b1;
          end else begin
            addr_q <= addr_q + P_OAM_AW'(1);
          end

          if (hit) begin
            if (room) begin
              for (int unsigned i = 0; i < P_MAX_SPR; i++) begin
                if (cnt_q == L_CW'(i)) begin
                  spr_q[i] <= i_oam_rdata;
                  row_q[i] <= diff[3:0];
                  is0_q[i] <= (p_idx_q == '0);
                end
              end
              cnt_q <= cnt_q + L_CW'(1);
            end else begin
              ovfl_q <= 1'b1;
            end
            if (p_idx_q == '0) begin
              spr0_q <= 1'b1;
            end
          end

          if (last) begin
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Slots at or beyond P_MAX_SPR read back as the fill pattern.
  always_comb begin
    o_rd_spr = '1;
    o_rd_row = '0;
    o_rd_is0 = 1'b0;
    for (int unsigned i = 0; i < P_MAX_SPR; i++) begin
      if (i_rd_idx == L_IW'(i)) begin
        o_rd_spr = spr_q[i];
        o_rd_row = row_q[i];
        o_rd_is0 = is0_q[i];
      end
    end
  end

  assign o_oam_addr = addr_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_spr_cnt  = cnt_q;
  assign o_ovfl     = ovfl_q;
  assign o_spr0_in  = spr0_q;

endmodule

// File: tb/tb_ppu_spr_eval.sv
module tb_ppu_spr_eval;

  typedef struct packed {
    logic [4:0]        cnt;
    logic              ovfl;
    logic              spr0;
    logic [15:0][31:0] spr;
    logic [15:0][3:0]  row;
    logic [15:0]       is0;
  } res_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  line = '0;
  logic        s16 = 1'b0;

  logic [5:0]  addr8, addr16;
  logic [31:0] rdata8, rdata16;
  logic        busy8, busy16, done8, done16;
  logic [3:0]  cnt8;
  logic [4:0]  cnt16;
  logic        ovfl8, ovfl16, spr08, spr016;
  logic [2:0]  rdidx8 = '0;
  logic [3:0]  rdidx16 = '0;
  logic [31:0] rdspr8, rdspr16;
  logic [3:0]  rdrow8, rdrow16;
  logic        rdis08, rdis016;

  logic [31:0] mem [64];
  logic        busy_tr [256];
  logic [5:0]  addr_tr [256];

  res_t q8[$];
  res_t q16[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rdata8  <= mem[addr8];
  always @(posedge clk) rdata16 <= mem[addr16];

  ppu_spr_eval #(.P_MAX_SPR(8), .P_OAM_AW(6)) dut8 (
    .i_ppu_clk(clk), .i_ppu_rstn(rstn), .i_start(start), .i_line(line),
    .i_spr_16(s16), .o_oam_addr(addr8), .i_oam_rdata(rdata8), .o_busy(busy8),
    .o_done(done8), .o_spr_cnt(cnt8), .o_ovfl(ovfl8), .o_spr0_in(spr08),
    .i_rd_idx(rdidx8), .o_rd_spr(rdspr8), .o_rd_row(rdrow8), .o_rd_is0(rdis08)
  );

  ppu_spr_eval #(.P_MAX_SPR(16), .P_OAM_AW(6)) dut16 (
    .i_ppu_clk(clk), .i_ppu_rstn(rstn), .i_start(start), .i_line(line),
    .i_spr_16(s16), .o_oam_addr(addr16), .i_oam_rdata(rdata16), .o_busy(busy16),
    .o_done(done16), .o_spr_cnt(cnt16), .o_ovfl(ovfl16), .o_spr0_in(spr016),
    .i_rd_idx(rdidx16), .o_rd_spr(rdspr16), .o_rd_row(rdrow16), .o_rd_is0(rdis016)
  );

  // Reference: walk OAM with plain integer range arithmetic.
  function automatic res_t model(input logic [7:0] ln, input logic tall, input int maxs);
    res_t r;
    r.cnt = '0; r.ovfl = 1'b0; r.spr0 = 1'b0;
    r.spr = '1; r.row = '0; r.is0 = '0;
    for (int k = 0; k < 64; k++) begin
      int y;
      int l;
      int h;
      y = int'(mem[k][7:0]);
      l = int'(ln);
      h = tall ? 16 : 8;
      if (l >= y && (l - y) < h) begin
        if (k == 0) r.spr0 = 1'b1;
        if (int'(r.cnt) < maxs) begin
          r.spr[r.cnt] = mem[k];
          r.row[r.cnt] = 4'(l - y);
          r.is0[r.cnt] = (k == 0);
          r.cnt = r.cnt + 5'd1;
        end else begin
          r.ovfl = 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic clear_mem();
    for (int k = 0; k < 64; k++) mem[k] = {$urandom_range(0, 32'hFF_FFFF) & 32'hFF_FFFF, 8'hFF} & 32'hFFFF_FFFF;
    for (int k = 0; k < 64; k++) mem[k][7:0] = 8'hFF;
  endtask

  task automatic set_y(input int k, input logic [7:0] y);
    mem[k] = {8'(k * 3), 8'(k ^ 8'h5A), 8'(k + 8'h40), y};
  endtask

  // Drive a start pulse (called at a negedge) and queue expected results.
  task automatic start_scan(input logic [7:0] ln, input logic tall);
    line = ln;
    s16  = tall;
    q8.push_back(model(ln, tall, 8));
    q16.push_back(model(ln, tall, 16));
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count cycles after the start edge until o_done; -1 on timeout.
  task automatic wait_done(input int pulse_at, output int cyc);
    bit found;
    found = 0;
    cyc = 0;
    while (!found && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      busy_tr[cyc] = busy8;
      addr_tr[cyc] = addr8;
      if (cyc == pulse_at - 1) start = 1'b1;
      if (cyc == pulse_at) start = 1'b0;
      if (done8) found = 1;
    end
    if (!found) cyc = -1;
  endtask

  task automatic observe(output res_t r8, output res_t r16);
    r8.cnt = {1'b0, cnt8}; r8.ovfl = ovfl8; r8.spr0 = spr08;
    r16.cnt = cnt16; r16.ovfl = ovfl16; r16.spr0 = spr016;
    r8.spr = '1; r8.row = '0; r8.is0 = '0;
    for (int i = 0; i < 16; i++) begin
      rdidx16 = 4'(i);
      if (i < 8) rdidx8 = 3'(i);
      #1;
      r16.spr[i] = rdspr16; r16.row[i] = rdrow16; r16.is0[i] = rdis016;
      if (i < 8) begin
        r8.spr[i] = rdspr8; r8.row[i] = rdrow8; r8.is0[i] = rdis08;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    rdidx8 = 3'd5;
    #23;
    n_checks++;
    if ({addr8, busy8, done8, cnt8, ovfl8, spr08} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", {addr8, busy8, done8, cnt8, ovfl8, spr08});
    end
    n_checks++;
    if ({rdspr8, rdrow8, rdis08} !== {32'hFFFF_FFFF, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_readout: got %h expected ffffffff00", {rdspr8, rdrow8, rdis08});
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_no_hits();
    res_t e8, e16, r8, r16;
    int cyc;
    clear_mem();
    start_scan(8'd10, 1'b0);
    wait_done(-10, cyc);
    n_checks++;
    if (cyc !== 66) begin n_fail++; $display("FAIL no_hits_latency: got %0d expected 66", cyc); end
    n_checks++;
    if (done16 !== 1'b1) begin n_fail++; $display("FAIL no_hits_done16: got %b expected 1", done16); end
    n_checks++;
    if ({busy_tr[1], busy_tr[64], busy_tr[65]} !== 3'b110) begin
      n_fail++;
      $display("FAIL busy_window: got %b expected 110", {busy_tr[1], busy_tr[64], busy_tr[65]});
    end
    n_checks++;
    if ({addr_tr[5], addr_tr[63], addr_tr[65]} !== {6'd5, 6'd63, 6'd63}) begin
      n_fail++;
      $display("FAIL addr_sequence: got %0d/%0d/%0d expected 5/63/63", addr_tr[5], addr_tr[63], addr_tr[65]);
    end
    observe(r8, r16);
    e8 = q8.pop_front(); e16 = q16.pop_front();
    n_checks++;
    if (r8 !== e8) begin n_fail++; $display("FAIL no_hits_sb8: got %h expected %h", r8, e8); end
    n_checks++;
    if ({r8.cnt, r8.ovfl, r8.spr0, r8.spr[7:0]} !== {7'd0, {8{32'hFFFF_FFFF}}}) begin
      n_fail++; $display("FAIL no_hits_const: got cnt %0d ovfl %b spr0 %b", r8.cnt, r8.ovfl, r8.spr0);
    end
  endtask

  task automatic test_three_hits();
    res_t e8, e16, r8, r16;
    int cyc;
    clear_mem();
    set_y(3, 8'd10); set_y(7, 8'd10); set_y(20, 8'd10);
    start_scan(8'd12, 1'b0);
    wait_done(-10, cyc);
    observe(r8, r16);
    e8 = q8.pop_front(); e16 = q16.pop_front();
    n_checks++;
    if (r8 !== e8) begin n_fail++; $display("FAIL three_sb8: got %h expected %h", r8, e8); end
    n_checks++;
    if (r16 !== e16) begin n_fail++; $display("FAIL three_sb16: got %h expected %h", r16, e16); end
    n_checks++;
    if ({r8.cnt, r8.spr[0], r8.row[0], r8.spr[2], r8.spr[3], r8.is0[7:0]} !==
        {5'd3, mem[3], 4'd2, mem[20], 32'hFFFF_FFFF, 8'h00}) begin
      n_fail++;
      $display("FAIL three_const: got cnt %0d s0 %h row %0d s2 %h s3 %h", r8.cnt, r8.spr[0], r8.row[0], r8.spr[2], r8.spr[3]);
    end
  endtask

  task automatic test_overflow();
    res_t e8, e16, r8, r16;
    int cyc;
    clear_mem();
    for (int k = 1; k <= 9; k++) set_y(k, 8'd50);
    start_scan(8'd50, 1'b0);
    wait_done(-10, cyc);
    observe(r8, r16);
    e8 = q8.pop_front(); e16 = q16.pop_front();
    n_checks++;
    if (r8 !== e8) begin n_fail++; $display("FAIL ovfl_sb8: got %h expected %h", r8, e8); end
    n_checks++;
    if ({r8.cnt, r8.ovfl, r8.spr[7]} !== {5'd8, 1'b1, mem[8]}) begin
      n_fail++; $display("FAIL ovfl_const: got cnt %0d ovfl %b s7 %h", r8.cnt, r8.ovfl, r8.spr[7]);
    end
    n_checks++;
    if (r16 !== e16) begin n_fail++; $display("FAIL ovfl_sb16_9: got %h expected %h", r16, e16); end

    for (int k = 10; k <= 12; k++) set_y(k + 30, 8'd47);
    start_scan(8'd50, 1'b0);
    wait_done(-10, cyc);
    observe(r8, r16);
    e8 = q8.pop_front(); e16 = q16.pop_front();
    n_checks++;
    if (r16 !== e16) begin n_fail++; $display("FAIL ovfl_sb16_12: got %h expected %h", r16, e16); end
    n_checks++;
    if ({r16.cnt, r16.ovfl, r16.spr[11], r16.row[11]} !== {5'd12, 1'b0, mem[42], 4'd3}) begin
      n_fail++; $display("FAIL ovfl16_const: got cnt %0d ovfl %b", r16.cnt, r16.ovfl);
    end
    n_checks++;
    if (r8 !== e8) begin n_fail++; $display("FAIL ovfl_sb8_12: got %h expected %h", r8, e8); end
  endtask

  task automatic test_tall_and_bounds();
    res_t e8, e16, r8, r16;
    int cyc;
    logic [7:0] lines [6];
    logic       talls [6];
    lines = '{8'd113, 8'd113, 8'd5, 8'd115, 8'd116, 8'd107};
    talls = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    clear_mem();
    set_y(5, 8'd100); set_y(6, 8'd250);
    for (int t = 0; t < 6; t++) begin
      start_scan(lines[t], talls[t]);
      wait_done(-10, cyc);
      observe(r8, r16);
      e8 = q8.pop_front(); e16 = q16.pop_front();
      n_checks++;
      if (r8 !== e8) begin n_fail++; $display("FAIL range_case%0d: got %h expected %h", t, r8, e8); end
    end
    start_scan(8'd113, 1'b1);
    wait_done(-10, cyc);
    observe(r8, r16);
    e8 = q8.pop_front(); e16 = q16.pop_front();
    n_checks++;
    if ({r8.cnt, r8.row[0], r8.spr[0]} !== {5'd1, 4'd13, mem[5]}) begin
      n_fail++; $display("FAIL tall_row: got cnt %0d row %0d expected cnt 1 row 13", r8.cnt, r8.row[0]);
    end
  endtask

  task automatic test_spr0_and_ignored_start();
    res_t e8, e16, r8, r16;
    int cyc;
    int extra;
    clear_mem();
    set_y(0, 8'd5);
    start_scan(8'd5, 1'b0);
    wait_done(20, cyc);
    n_checks++;
    if (cyc !== 66) begin n_fail++; $display("FAIL ignored_start_latency: got %0d expected 66", cyc); end
    observe(r8, r16);
    e8 = q8.pop_front(); e16 = q16.pop_front();
    n_checks++;
    if (r8 !== e8) begin n_fail++; $display("FAIL spr0_sb8: got %h expected %h", r8, e8); end
    n_checks++;
    if ({r8.spr0, r8.is0[0], r8.row[0], r8.cnt} !== {1'b1, 1'b1, 4'd0, 5'd1}) begin
      n_fail++; $display("FAIL spr0_const: got spr0 %b is0 %b row %0d", r8.spr0, r8.is0[0], r8.row[0]);
    end
    extra = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done8 || busy8) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL start_not_queued: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_reset_mid_scan();
    res_t e8, e16, r8, r16;
    int cyc;
    int extra;
    clear_mem();
    set_y(0, 8'd30); set_y(3, 8'd28); set_y(40, 8'd31);
    start_scan(8'd33, 1'b0);
    for (int c = 1; c <= 30; c++) @(negedge clk);
    rstn = 1'b0;
    rdidx8 = 3'd0;
    #1;
    n_checks++;
    if ({busy8, busy16, addr8, cnt8, ovfl8, spr08, done8} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got busy %b addr %0d cnt %0d spr0 %b", busy8, addr8, cnt8, spr08);
    end
    n_checks++;
    if ({rdspr8, rdrow8, rdis08} !== {32'hFFFF_FFFF, 4'h0, 1'b0}) begin
      n_fail++; $display("FAIL midreset_buffer: got %h expected ffffffff00", {rdspr8, rdrow8, rdis08});
    end
    void'(q8.pop_front()); void'(q16.pop_front());
    @(negedge clk);
    rstn = 1'b1;
    extra = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done8 || busy8) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d active cycles expected 0", extra); end
    start_scan(8'd33, 1'b0);
    wait_done(-10, cyc);
    n_checks++;
    if (cyc !== 66) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 66", cyc); end
    observe(r8, r16);
    e8 = q8.pop_front(); e16 = q16.pop_front();
    n_checks++;
    if (r8 !== e8) begin n_fail++; $display("FAIL post_reset_sb8: got %h expected %h", r8, e8); end
    n_checks++;
    if (r16 !== e16) begin n_fail++; $display("FAIL post_reset_sb16: got %h expected %h", r16, e16); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'hFFFF_FFFF;
    test_reset();
    test_no_hits();
    test_three_hits();
    test_overflow();
    test_tall_and_bounds();
    test_spr0_and_ignored_start();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ppu_spr_eval.md
# ppu_spr_eval

Per-scanline sprite evaluation engine for the PPU, in the `i_ppu_clk` domain. It scans the primary OAM through the 64x32 read port of the OAM dual-port RAM. It copies up to `P_MAX_SPR` in-range sprites, in OAM order, into an internal secondary buffer. It reports hit count, a true overflow flag and sprite-0 presence for the sprite pipeline and `ppu_cfg` status bits. It generalises the fixed NES 8-sprite evaluator:

- the per-line limit is a parameter;
- 8x16 mode is supported;
- overflow is computed exactly, without the 2C02 diagonal-scan bug.

## Interface
Parameters:
- `P_MAX_SPR`, default 8: secondary buffer depth (sprites per line); legal range 1..64.
- `P_OAM_AW`, default 6: OAM word address width (64 entries).
- Derived localparams:
  - `L_IW = max(1, $clog2(P_MAX_SPR))`: slot index width.
  - `L_CW = $clog2(P_MAX_SPR+1)`: count width.

Ports:
- `i_ppu_clk`  in  1  clock.
- `i_ppu_rstn`  in  1  asynchronous active-low reset.
- `i_start`  in  1  one-cycle pulse that begins evaluation; ignored while busy.
- `i_line`  in  8  target scanline; sampled with `i_start`.
- `i_spr_16`  in  1  1 selects 8x16 sprites, 0 selects 8x8; sampled with `i_start`.
- `o_oam_addr`  out  `P_OAM_AW`  OAM word address, driving RAM `address_b`.
- `i_oam_rdata`  in  32  OAM word. Byte layout: `[7:0]` Y, `[15:8]` tile, `[23:16]` attr, `[31:24]` X. Valid one cycle after the address is registered by the RAM.
- `o_busy`  out  1  scan in progress.
- `o_done`  out  1  one-cycle pulse when results are valid.
- `o_spr_cnt`  out  `L_CW`  number of sprites stored.
- `o_ovfl`  out  1  more than `P_MAX_SPR` sprites were in range.
- `o_spr0_in`  out  1  OAM entry 0 was in range.
- `i_rd_idx`  in  `L_IW`  secondary buffer read slot.
- `o_rd_spr`  out  32  stored OAM word for that slot (combinational read).
- `o_rd_row`  out  4  row within the sprite, computed as line − Y.
- `o_rd_is0`  out  1  the slot holds OAM entry 0.

## Operation
- FSM states are IDLE, SCAN and DONE.
- **IDLE**: when `i_start` is high:
  - latch `i_line` and `i_spr_16`;
  - clear the count, `o_ovfl` and `o_spr0_in`;
  - fill every slot with spr=32'hFFFF_FFFF, row=0, is0=0;
  - set addr=0 and go to SCAN.
- **SCAN**: `o_oam_addr` increments by 1 each cycle from 0 to 63 and then holds at 63. A two-stage valid/index pipeline tracks which entry is on `i_oam_rdata`. For each returned entry k:
  - compute the 9-bit difference d = {0, line} − {0, Y};
  - the entry is a hit iff d[8]==0 and d[7:0] < 8 (8x8) or < 16 (8x16); there is no wrap-around, so Y > line is a miss;
  - on a hit with count < `P_MAX_SPR`: write the slot[count] word, row d[3:0] and is0=(k==0), then increment count;
  - on a hit with count == `P_MAX_SPR`: set `o_ovfl`; count saturates;
  - on a hit at k==0: set `o_spr0_in`.
- All 64 entries are always scanned, even once the buffer is full.
- After entry 63 is evaluated, go to DONE.
- **DONE**: assert `o_done` for one cycle, then return to IDLE.
- `o_spr_cnt`, `o_ovfl`, `o_spr0_in` and the buffer hold their values until the next accepted `i_start`.
- An `i_rd_idx` at or above `P_MAX_SPR` (non-power-of-two depth) returns the FF fill pattern.
- `i_start` in SCAN or DONE is ignored; it is not queued.

## Timing
- Reset values:
  - all outputs 0, except `o_rd_spr` = 32'hFFFF_FFFF;
  - FSM in IDLE;
  - buffer holds the FF fill pattern.
- Edge numbering: E0 is the edge that samples `i_start`. `o_oam_addr` is k during the cycle after edge E(k), for k=0..63.
- Entry k is evaluated and written at edge E(k+2). The last entry is written at E65.
- `o_busy` is high from after E0 until after E65.
- `o_done` is high in the single cycle after E66. Evaluation latency is therefore 66 cycles, and the next `i_start` is accepted at E67.
- Buffer readout has zero-cycle latency from `i_rd_idx`.
- Reset asserted mid-scan immediately forces IDLE and reset values; no `o_done` is generated.

## Test plan
- **All Y=0xFF, line=10:** the scan must see no hits.
  - Expect `o_done` 66 cycles after start, cnt=0, ovfl=0 and spr0_in=0.
  - All slots read 0xFFFFFFFF.
- **Entries 3, 7, 20 with Y=10, line=12, 8x8:**
  - Expect cnt=3.
  - Slot0 = entry 3 word with row=2; slot2 = entry 20.
  - Slot3 reads 0xFFFFFFFF and is0=0 everywhere.
- **Nine entries (1..9) with Y=50, line=50, `P_MAX_SPR`=8:**
  - Expect cnt=8, ovfl=1.
  - Slot7 = entry 8; entry 9 is not stored.
  - With `P_MAX_SPR`=16 and 12 hits: cnt=12, ovfl=0.
- **Y=100, line=113:**
  - 8x16: hit, row=13.
  - 8x8: miss, cnt=0.
  - Y=250, line=5: miss (no wrap).
- **Entry 0 with Y=5, line=5:**
  - Expect spr0_in=1, slot0 is0=1, row=0.
  - A second `i_start` pulsed at E20 is ignored; `o_done` still follows the first start only.
- **Reset mid-scan:** assert `i_ppu_rstn`=0 at E30 of a scan with hits.
  - Outputs go immediately to reset values, busy=0, and no `o_done` follows.
  - A fresh start then completes normally.
